// File: rtl/axi_riscv_amos_perf_ctrl_pkg.sv
// axi_riscv_amos_perf_pkg: register map, FSM states and bit positions for the perf counter controller
package axi_riscv_amos_perf_pkg;

   localparam int OFF_CTRL   = 0;
   localparam int OFF_ENABLE = 1;
   localparam int OFF_CLEAR  = 2;
   localparam int OFF_STATUS = 3;
   localparam int OFF_SNAP   = 16;

   localparam int CTRL_GLOBAL_EN_BIT    = 0;
   localparam int CTRL_SNAP_BIT         = 1;
   localparam int STATUS_SNAP_VALID_BIT = 0;
   localparam int STATUS_CLEAR_BUSY_BIT = 1;

   typedef enum logic {
      IDLE,
      CLEARING
   } state_e;

endpackage

// File: rtl/axi_riscv_amos_perf_ctrl_if.sv
// axi_riscv_amos_perf_ctrl_if: request/grant register port of the perf counter controller
interface axi_riscv_amos_perf_ctrl_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 64
);
   logic                  req_i;
   logic                  we_i;
   logic [ADDR_WIDTH-1:0] addr_i;
   logic [DATA_WIDTH-1:0] wdata_i;
   logic                  gnt_o;
   logic                  rvalid_o;
   logic [DATA_WIDTH-1:0] rdata_o;
   logic                  err_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o, err_o
   );
endinterface

// File: rtl/axi_riscv_amos_perf_ctrl.sv
// axi_riscv_amos_perf_ctrl: counter activate/reset control, timed clears and atomic snapshot readout
module axi_riscv_amos_perf_ctrl
   import axi_riscv_amos_perf_pkg::*;
#(
   parameter int NUM_CNT    = 32,
   parameter int CNT_WIDTH  = 64,
   parameter int CLR_CYCLES = 2,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   axi_riscv_amos_perf_ctrl_if.slave         reg_if,
   input  logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_i,
   output logic [NUM_CNT-1:0]                cnt_act_o,
   output logic [NUM_CNT-1:0]                cnt_rst_no
);

   localparam int ADDR_LSB = $clog2(CNT_WIDTH / 8);
   localparam int IW       = ADDR_WIDTH - ADDR_LSB;

   state_e                            r_state;
   logic                              r_global_en;
   logic [NUM_CNT-1:0]                r_enable;
   logic [NUM_CNT-1:0]                r_clr_mask;
   logic [3:0]                        r_clr_cnt;
   logic                              r_snap_valid;
   logic [NUM_CNT-1:0][CNT_WIDTH-1:0] r_snap;
   logic                              r_rvalid;
   logic [CNT_WIDTH-1:0]              r_rdata;
   logic                              r_err;

   logic [IW-1:0]        w_idx;
   logic                 w_gnt;
   logic                 w_rd_ok;
   logic                 w_wr_ok;
   logic                 w_err;
   logic                 w_wr;
   logic [CNT_WIDTH-1:0] w_rdata;
   logic [NUM_CNT-1:0]   w_clr;
   logic                 w_is_ctrl;
   logic                 w_is_snap;
   logic                 w_unused;

   assign w_idx     = reg_if.addr_i[ADDR_WIDTH-1:ADDR_LSB];
   assign w_gnt     = reg_if.req_i && (r_state == IDLE);
   assign w_err     = reg_if.we_i ? !w_wr_ok : !w_rd_ok;
   assign w_wr      = w_gnt && reg_if.we_i && !w_err;
   assign w_clr     = reg_if.wdata_i[NUM_CNT-1:0];
   assign w_is_ctrl = (w_idx == IW'(OFF_CTRL));
   assign w_is_snap = (w_idx >= IW'(OFF_SNAP)) && (w_idx < IW'(OFF_SNAP + NUM_CNT));
   assign w_unused  = ^{reg_if.addr_i, reg_if.wdata_i};

   // address decode: legality per direction and read data mux
   always_comb begin
      w_rd_ok = 1'b0;
      w_wr_ok = 1'b0;
      w_rdata = '0;
      if (w_is_ctrl) begin
         w_rd_ok = 1'b1;
         w_wr_ok = 1'b1;
         w_rdata[CTRL_GLOBAL_EN_BIT] = r_global_en;
      end else if (w_idx == IW'(OFF_ENABLE)) begin
         w_rd_ok = 1'b1;
         w_wr_ok = 1'b1;
         w_rdata[NUM_CNT-1:0] = r_enable;
      end else if (w_idx == IW'(OFF_CLEAR)) begin
         w_rd_ok = 1'b1;
         w_wr_ok = 1'b1;
      end else if (w_idx == IW'(OFF_STATUS)) begin
         w_rd_ok = 1'b1;
         w_rdata[STATUS_SNAP_VALID_BIT] = r_snap_valid;
         w_rdata[STATUS_CLEAR_BUSY_BIT] = (r_state == CLEARING);
      end else if (w_is_snap) begin
         w_rd_ok = 1'b1;
         for (int i = 0; i < NUM_CNT; i++)
            if (w_idx == IW'(OFF_SNAP + i)) w_rdata = r_snap[i];
      end
   end

   // registered response: one rvalid per grant, data only for legal reads
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_rvalid <= w_gnt;
         r_err    <= w_gnt && w_err;
         r_rdata  <= (w_gnt && !reg_if.we_i && !w_err) ? w_rdata : '0;
      end
   end

   // config registers and clear sequencer; requests stall while a clear is in flight
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= IDLE;
         r_global_en  <= 1'b0;
         r_enable     <= '0;
         r_clr_mask   <= '0;
         r_clr_cnt    <= '0;
         r_snap_valid <= 1'b0;
      end else if (r_state == IDLE) begin
         if (w_wr && w_is_ctrl) begin
            r_global_en <= reg_if.wdata_i[CTRL_GLOBAL_EN_BIT];
            if (reg_if.wdata_i[CTRL_SNAP_BIT]) r_snap_valid <= 1'b1;
         end
         if (w_wr && w_idx == IW'(OFF_ENABLE)) r_enable <= reg_if.wdata_i[NUM_CNT-1:0];
         if (w_wr && w_idx == IW'(OFF_CLEAR) && |w_clr) begin
            r_clr_mask <= w_clr;
            r_clr_cnt  <= 4'(CLR_CYCLES);
            r_state    <= CLEARING;
         end
      end else begin
         r_clr_cnt <= r_clr_cnt - 4'd1;
         if (r_clr_cnt == 4'd1) begin
            r_state      <= IDLE;
            r_clr_mask   <= '0;
            r_snap_valid <= 1'b0;
         end
      end
   end

   // shadow bank: all counters captured on the same edge
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_snap <= '0;
      else if (w_wr && w_is_ctrl && reg_if.wdata_i[CTRL_SNAP_BIT]) r_snap <= cnt_i;
   end

   assign reg_if.gnt_o    = w_gnt;
   assign reg_if.rvalid_o = r_rvalid;
   assign reg_if.rdata_o  = r_rdata;
   assign reg_if.err_o    = r_err;
   assign cnt_act_o       = r_enable & {NUM_CNT{r_global_en}} & ~r_clr_mask;
   assign cnt_rst_no      = ~r_clr_mask;

endmodule

// File: tb/tb_axi_riscv_amos_perf_ctrl.sv
// tb_axi_riscv_amos_perf_ctrl: directed checks of register port, clears, snapshot and errors
module tb_axi_riscv_amos_perf_ctrl;
   localparam int NC = 4;
   localparam int CW = 64;
   localparam int AW = 12;
   localparam logic [AW-1:0] A_CTRL = 12'd0, A_EN = 12'd8, A_CLR = 12'd16, A_STAT = 12'd24;
   localparam logic [AW-1:0] A_OFF7 = 12'd56, A_S0 = 12'd128, A_S1 = 12'd136, A_S2 = 12'd144;
   localparam logic [AW-1:0] A_S3 = 12'd152, A_S4 = 12'd160;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [NC-1:0][CW-1:0]  cnt = '0;
   logic [NC-1:0][CW-1:0]  cap;
   logic [NC-1:0][CW-1:0]  snap;
   logic [NC-1:0]          act;
   logic [NC-1:0]          rstn_v;
   int                     total = 0;
   int                     bad = 0;
   int                     cyc = 0;

   axi_riscv_amos_perf_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(CW)) bus ();

   axi_riscv_amos_perf_ctrl #(
      .NUM_CNT(NC), .CNT_WIDTH(CW), .CLR_CYCLES(2), .ADDR_WIDTH(AW)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .reg_if(bus),
      .cnt_i(cnt), .cnt_act_o(act), .cnt_rst_no(rstn_v)
   );

   always #5 clk = ~clk;

   // live counters change every cycle, away from the sampling edge
   always @(negedge clk) begin
      cyc++;
      cnt[0] = 64'h0000_0000_00C0_FFEE;
      cnt[1] = 64'h1234 + 64'(cyc);
      cnt[2] = 64'hABCD + 64'(cyc * 3);
      cnt[3] = 64'hDEAD_0000_0000_0000 | 64'(cyc);
   end

   task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic access(input logic w, input logic [AW-1:0] a, input logic [CW-1:0] d,
                         output logic [CW-1:0] r, output logic e);
      int n = 0;
      @(negedge clk);
      bus.req_i = 1'b1; bus.we_i = w; bus.addr_i = a; bus.wdata_i = d;
      #1;
      while (!bus.gnt_o && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      if (!bus.gnt_o) begin
         chk("gnt_timeout", 0, 1);
         bus.req_i = 1'b0;
         r = '0;
         e = 1'b1;
      end else begin
         @(posedge clk);
         cap = cnt;
         @(negedge clk);
         chk("rvalid", bus.rvalid_o, 1);
         r = bus.rdata_o;
         e = bus.err_o;
         bus.req_i = 1'b0;
      end
   endtask

   task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [CW-1:0] exp, input logic exp_e);
      logic [CW-1:0] r;
      logic e;
      access(1'b0, a, '0, r, e);
      chk({tag, "_data"}, r, exp);
      chk({tag, "_err"}, e, exp_e);
   endtask

   task automatic wr_chk(input string tag, input logic [AW-1:0] a, input logic [CW-1:0] d, input logic exp_e);
      logic [CW-1:0] r;
      logic e;
      access(1'b1, a, d, r, e);
      chk({tag, "_data"}, r, 0);
      chk({tag, "_err"}, e, exp_e);
   endtask

   initial begin
      bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
      #2;
      chk("rst_gnt", bus.gnt_o, 0);
      chk("rst_rvalid", bus.rvalid_o, 0);
      chk("rst_rdata", bus.rdata_o, 0);
      chk("rst_err", bus.err_o, 0);
      chk("rst_act", act, 0);
      chk("rst_rstn", rstn_v, 4'hF);
      @(negedge clk);
      rst_n = 1'b1;

      rd_chk("status0", A_STAT, 0, 0);
      @(negedge clk);
      chk("rvalid_single", bus.rvalid_o, 0);

      wr_chk("en5", A_EN, 64'h5, 0);
      wr_chk("ctrl1", A_CTRL, 64'h1, 0);
      chk("act5", act, 4'h5);
      rd_chk("en_rd", A_EN, 64'h5, 0);
      rd_chk("ctrl_rd", A_CTRL, 64'h1, 0);
      wr_chk("ctrl0", A_CTRL, 64'h0, 0);
      chk("act0", act, 4'h0);

      wr_chk("enF", A_EN, 64'hF, 0);
      wr_chk("ctrl1b", A_CTRL, 64'h1, 0);
      chk("actF", act, 4'hF);
      wr_chk("clr6", A_CLR, 64'h6, 0);
      chk("clr_rstn0", rstn_v, 4'h9);
      chk("clr_act", act, 4'h9);
      bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = A_STAT;
      #1;
      chk("clr_gnt0", bus.gnt_o, 0);
      @(negedge clk); #1;
      chk("clr_rstn1", rstn_v, 4'h9);
      chk("clr_gnt1", bus.gnt_o, 0);
      chk("clr_rvalid1", bus.rvalid_o, 0);
      @(negedge clk); #1;
      chk("clr_rstn2", rstn_v, 4'hF);
      chk("clr_act2", act, 4'hF);
      chk("clr_gnt2", bus.gnt_o, 1);
      @(posedge clk);
      @(negedge clk);
      chk("clr_st_rvalid", bus.rvalid_o, 1);
      chk("clr_st_data", bus.rdata_o, 0);
      chk("clr_st_err", bus.err_o, 0);
      bus.req_i = 1'b0;

      wr_chk("clr0", A_CLR, 64'h0, 0);
      chk("clr0_rstn", rstn_v, 4'hF);
      rd_chk("clr0_rd", A_CLR, 0, 0);

      wr_chk("snap", A_CTRL, 64'h3, 0);
      snap = cap;
      chk("snap_act", act, 4'hF);
      rd_chk("snap0", A_S0, snap[0], 0);
      rd_chk("snap1", A_S1, snap[1], 0);
      rd_chk("snap2", A_S2, snap[2], 0);
      rd_chk("snap3", A_S3, snap[3], 0);
      rd_chk("snap_stat", A_STAT, 64'h1, 0);
      rd_chk("snap_ctrl", A_CTRL, 64'h1, 0);

      rd_chk("err_off7", A_OFF7, 0, 1);
      wr_chk("err_wsnap", A_S0, 64'hFFFF, 1);
      rd_chk("err_snap0_kept", A_S0, snap[0], 0);
      rd_chk("err_snap4", A_S4, 0, 1);
      wr_chk("err_wstat", A_STAT, 64'h3, 1);
      rd_chk("err_stat_kept", A_STAT, 64'h1, 0);
      wr_chk("err_woff7", A_OFF7, 64'h0, 1);
      rd_chk("err_en_kept", A_EN, 64'hF, 0);
      rd_chk("err_ctrl_kept", A_CTRL, 64'h1, 0);

      wr_chk("clr1", A_CLR, 64'h1, 0);
      chk("clr1_rstn", rstn_v, 4'hE);
      rd_chk("clr1_stat", A_STAT, 64'h0, 0);
      rd_chk("clr1_snap1", A_S1, snap[1], 0);

      wr_chk("clrF", A_CLR, 64'hF, 0);
      chk("clrF_rstn", rstn_v, 4'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rstn", rstn_v, 4'hF);
      chk("mid_rst_act", act, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = A_STAT;
      #1;
      chk("mid_rst_gnt", bus.gnt_o, 1);
      bus.req_i = 1'b0;
      rd_chk("mid_rst_en", A_EN, 0, 0);
      rd_chk("mid_rst_snap1", A_S1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/axi_riscv_amos_perf_ctrl.md
Name: axi_riscv_amos_perf_ctrl

Overview:
- Configuration and readout controller for the performance counters of the AXI RISC-V AMO adapter.
- Drives the adapter's per-counter activate and active-low reset vectors from a simple request/grant register port.
- Sequences multi-cycle counter clears.
- Captures all counter values atomically into a shadow bank so software reads a consistent snapshot.
- Sits next to the AMO wrapper, with the register port hanging off the peripheral interconnect.

Parameters:
- NUM_CNT, 32, number of counters; 1..32.
- CNT_WIDTH, 64, counter width, equal to the adapter's RISCV_WORD_WIDTH; 32 or 64; also the register data width.
- CLR_CYCLES, 2, cycles the counter reset is held low per clear; 1..15.
- ADDR_WIDTH, 12, register byte-address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  register request valid.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  byte address, word-aligned to CNT_WIDTH/8.
- wdata_i  in  CNT_WIDTH  write data.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  response valid, exactly one per grant.
- rdata_o  out  CNT_WIDTH  read data; 0 on writes.
- err_o  out  1  decode error flag, qualified by rvalid_o.
- cnt_i  in  NUM_CNT x CNT_WIDTH  live counter values from the adapter.
- cnt_act_o  out  NUM_CNT  per-counter activate to the adapter.
- cnt_rst_no  out  NUM_CNT  per-counter active-low reset to the adapter.

Behaviour:
- Reset (asynchronous, active-low): all registers 0, FSM IDLE, gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, cnt_act_o=0, cnt_rst_no=all-ones, snapshot bank 0, SNAP_VALID=0.
- Register map. Offsets are word indices; byte address = index * CNT_WIDTH/8.
  - 0 CTRL rw: bit0 GLOBAL_EN; bit1 SNAP, self-clearing, reads 0.
  - 1 ENABLE rw: [NUM_CNT-1:0] per-counter enable; upper bits read 0.
  - 2 CLEAR wo: write 1 to start a clear of that counter; reads 0.
  - 3 STATUS ro: bit0 SNAP_VALID, bit1 CLEAR_BUSY.
  - 16+i SNAP[i] ro: shadow value of counter i.
- Decode errors: any other offset, a write to STATUS or SNAP, or i>=NUM_CNT → err_o=1, no state change, rdata_o=0.
- Handshake:
  - gnt_o = req_i && state==IDLE, combinational.
  - The response is registered: rvalid_o is asserted the cycle after the grant, for one cycle.
  - Back-to-back grants give back-to-back responses.
  - There is no backpressure on the response.
- cnt_act_o = ENABLE & {NUM_CNT{GLOBAL_EN}} & ~clr_mask_q while IDLE. While CLEARING, masked counters have act=0.
- FSM:
  - IDLE: a granted CLEAR write with nonzero masked data latches clr_mask_q = wdata & valid-mask, loads the down-counter with CLR_CYCLES, and moves to CLEARING.
  - IDLE: a CLEAR write of 0 is a no-op with no error.
  - CLEARING: cnt_rst_no = ~clr_mask_q. The down-counter decrements each cycle. gnt_o=0, so all requests stall.
  - CLEARING: when the counter reaches 1 and decrements, the FSM returns to IDLE, cnt_rst_no returns to all-ones and clr_mask_q is cleared.
  - Total low time is exactly CLR_CYCLES cycles, starting the cycle after the grant.
- Snapshot:
  - A granted CTRL write with bit1=1 copies every cnt_i[i] into SNAP[i] on the next clock edge, all counters in the same cycle.
  - The same write sets SNAP_VALID=1. The GLOBAL_EN bit in the same write still takes effect.
  - A CLEAR completing afterwards clears SNAP_VALID. SNAP values are retained until the next snapshot.
- Simultaneous events: a single-port interface carries one access per cycle, so no intra-cycle conflicts arise.
- Reset mid-clear: the FSM returns to IDLE immediately and cnt_rst_no returns to all-ones asynchronously.

Decomposition:
- Package axi_riscv_amos_perf_pkg:
  - register offset localparams;
  - FSM state enum {IDLE, CLEARING};
  - CTRL/STATUS bit-position constants.
- No sub-module is needed: decode, FSM and shadow bank fit one module.
- Optional: a shared counter-clear sequencer axi_riscv_amos_perf_clr for reuse. Default is inline.

Test Plan:
- After reset, read STATUS → rvalid one cycle after grant, rdata=0, err=0; cnt_rst_no=all-ones; cnt_act_o=0.
- Write ENABLE=0x5 then CTRL=0x1 → cnt_act_o=0x5 from the cycle after the second grant; write CTRL=0x0 → cnt_act_o=0.
- NUM_CNT=4, CLR_CYCLES=2: write CLEAR=0x6 → cnt_rst_no=0x9 for exactly 2 cycles; gnt_o=0 under a pending req_i during those cycles; a read of STATUS issued during the clear is granted afterward and returns 0.
- cnt_i[1]=0x1234 and cnt_i[2]=0xABCD, changing every cycle; write CTRL=0x3 → SNAP[1] and SNAP[2] equal the cnt_i values at the edge after the grant; STATUS bit0=1.
- Read offset 7, write SNAP[0], read SNAP[NUM_CNT] → err_o=1 and rdata=0 on each; no register changes.
- Assert rst_ni low mid-CLEARING → cnt_rst_no=all-ones immediately and the FSM is IDLE after release.
